zz_pipe_alu_accum: RTL

//   Parametrised, pipelined successor to the top-level combinational adder.

---
 rtl/zz_pipe_alu_accum.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/zz_pipe_alu_accum.sv
// Two-stage pipelined ALU with add, subtract, accumulate and clear operations.
// Overflow on any op either saturates or wraps, selected by SATURATE.
module zz_pipe_alu_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     result,
  output logic                 ovf,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  // Stage 1: captured operands
  logic                 v1_q, v1_d;
  mode_e                mode1_q, mode1_d;
  logic [WIDTH-1:0]     a1_q, a1_d;
  logic [WIDTH-1:0]     b1_q, b1_d;

  // Stage 2: registered outputs and accumulator state
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 acc_ovf_q, acc_ovf_d;

  logic [WIDTH:0]       sum_w;
  logic [WIDTH-1:0]     diff_w;
  logic                 borrow_w;
  logic [ACC_WIDTH:0]   acc_sum_w;
  logic                 acc_carry_w;
  logic [ACC_WIDTH-1:0] acc_new_w;

  always_comb begin
    sum_w       = {1'b0, a1_q} + {1'b0, b1_q};
    diff_w      = a1_q - b1_q;
    borrow_w    = (b1_q > a1_q);
    // The full (a+b) carry is kept so ACC adds the true operand sum.
    acc_sum_w   = {1'b0, acc_q} + {{(ACC_WIDTH-WIDTH){1'b0}}, sum_w};
    acc_carry_w = acc_sum_w[ACC_WIDTH];
    if (acc_carry_w && (SATURATE != 0)) begin
      acc_new_w = {ACC_WIDTH{1'b1}};
    end else begin
      acc_new_w = acc_sum_w[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    v1_d    = v1_q;
    mode1_d = mode1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    if (ena) begin
      v1_d    = in_valid;
      mode1_d = mode_e'(mode);
      a1_d    = a;
      b1_d    = b;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    acc_ovf_d   = acc_ovf_q;
    if (ena) begin
      out_valid_d = v1_q;
      if (v1_q) begin
        unique case (mode1_q)
          MODE_ADD: begin
            ovf_d = sum_w[WIDTH];
            if (sum_w[WIDTH] && (SATURATE != 0)) begin
              result_d = {WIDTH{1'b1}};
            end else begin
              result_d = sum_w[WIDTH-1:0];
            end
          end
          MODE_SUB: begin
            ovf_d = borrow_w;
            if (borrow_w && (SATURATE != 0)) begin
              result_d = '0;
            end else begin
              result_d = diff_w;
            end
          end
          MODE_ACC: begin
            ovf_d     = acc_carry_w;
            acc_d     = acc_new_w;
            acc_ovf_d = acc_ovf_q | acc_carry_w;
            result_d  = acc_new_w[WIDTH-1:0];
          end
          MODE_CLR: begin
            ovf_d     = 1'b0;
            acc_d     = '0;
            acc_ovf_d = 1'b0;
            result_d  = '0;
          end
          default: begin
            ovf_d = ovf_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      mode1_q     <= MODE_ADD;
      a1_q        <= '0;
      b1_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      mode1_q     <= mode1_d;
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;
  assign acc       = acc_q;
  assign acc_ovf   = acc_ovf_q;

endmodule
